tile_router_pe_arbiter: RTL and testbench

Merges the four PE output streams from the tile router's PE interface into one 64-bit router-bound stream. Each PE presents a 64-bit valid/accept channel. The block grants one PE at a time, round-robin, for bursts of up to BURST_LEN beats. Each beat is forwarded through a single registered output stage and tagged with its 2-bit source PE index.

---
 rtl/tile_router_pe_arbiter.sv | 145 ++++++++++++++
 tb/tb_tile_router_pe_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_router_pe_arbiter.sv
// Round-robin burst arbiter merging four PE output streams into one
// registered, source-tagged router-bound stream.
module tile_router_pe_arbiter #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned BURST_LEN  = 8,
   parameter int unsigned CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] pe0_datain,
   input  logic                  pe0_datain_valid,
   output logic                  pe0_datain_accept,
   input  logic [DATA_WIDTH-1:0] pe1_datain,
   input  logic                  pe1_datain_valid,
   output logic                  pe1_datain_accept,
   input  logic [DATA_WIDTH-1:0] pe2_datain,
   input  logic                  pe2_datain_valid,
   output logic                  pe2_datain_accept,
   input  logic [DATA_WIDTH-1:0] pe3_datain,
   input  logic                  pe3_datain_valid,
   output logic                  pe3_datain_accept,
   output logic [DATA_WIDTH-1:0] router_dataout,
   output logic [1:0]            router_dataout_src,
   output logic                  router_dataout_valid,
   input  logic                  router_dataout_accept
);

   localparam int unsigned NUM_PE    = 4;
   localparam int unsigned IDX_WIDTH = 2;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t                 state, state_n;
   logic [IDX_WIDTH-1:0]   rr_ptr, rr_ptr_n;
   logic [IDX_WIDTH-1:0]   grant_idx, grant_idx_n;
   logic [CNT_WIDTH-1:0]   beat_cnt, beat_cnt_n;
   logic [NUM_PE-1:0]      req;
   logic [NUM_PE-1:0]      accept_vec;
   logic [DATA_WIDTH-1:0]  sel_data;
   logic                   out_ready;
   logic                   grant_valid;
   logic                   xfer;
   logic                   burst_end;
   logic                   found;
   logic [IDX_WIDTH-1:0]   scan_idx;

   assign req         = {pe3_datain_valid, pe2_datain_valid, pe1_datain_valid, pe0_datain_valid};
   assign out_ready   = ~router_dataout_valid | router_dataout_accept;
   assign grant_valid = req[grant_idx];
   // Reset gates the handshake so no PE beat is consumed while rst is high.
   assign xfer        = (state == BURST) & grant_valid & out_ready & ~rst;
   assign accept_vec  = xfer ? (NUM_PE'(1) << grant_idx) : '0;

   assign pe0_datain_accept = accept_vec[0];
   assign pe1_datain_accept = accept_vec[1];
   assign pe2_datain_accept = accept_vec[2];
   assign pe3_datain_accept = accept_vec[3];

   // Select the granted PE's beat for the output register.
   always_comb begin
      sel_data = pe0_datain;
      case (grant_idx)
         2'd0:    sel_data = pe0_datain;
         2'd1:    sel_data = pe1_datain;
         2'd2:    sel_data = pe2_datain;
         default: sel_data = pe3_datain;
      endcase
   end

   // Arbiter state, round-robin pointer, grant and beat counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         grant_idx <= '0;
         beat_cnt  <= '0;
      end else begin
         state     <= state_n;
         rr_ptr    <= rr_ptr_n;
         grant_idx <= grant_idx_n;
         beat_cnt  <= beat_cnt_n;
      end
   end

   // Next-state: round-robin scan in IDLE, burst length / truncation tracking in BURST.
   always_comb begin
      state_n     = state;
      rr_ptr_n    = rr_ptr;
      grant_idx_n = grant_idx;
      beat_cnt_n  = beat_cnt;
      burst_end   = 1'b0;
      found       = 1'b0;
      scan_idx    = rr_ptr;
      case (state)
         IDLE: begin
            for (int i = 0; i < int'(NUM_PE); i++) begin
               scan_idx = rr_ptr + IDX_WIDTH'(i);
               if (!found && req[scan_idx]) begin
                  found       = 1'b1;
                  grant_idx_n = scan_idx;
               end
            end
            if (found) begin
               state_n    = BURST;
               beat_cnt_n = '0;
            end
         end
         BURST: begin
            if (xfer) begin
               if (beat_cnt == CNT_WIDTH'(BURST_LEN - 1)) begin
                  burst_end = 1'b1;
               end else begin
                  beat_cnt_n = beat_cnt + CNT_WIDTH'(1);
               end
            end else if (!grant_valid && out_ready) begin
               burst_end = 1'b1;
            end
            if (burst_end) begin
               state_n  = IDLE;
               rr_ptr_n = grant_idx + IDX_WIDTH'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Single output register stage; holds while downstream stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         router_dataout       <= '0;
         router_dataout_src   <= '0;
         router_dataout_valid <= 1'b0;
      end else if (xfer) begin
         router_dataout       <= sel_data;
         router_dataout_src   <= grant_idx;
         router_dataout_valid <= 1'b1;
      end else if (router_dataout_accept) begin
         router_dataout_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tile_router_pe_arbiter.sv
// Self-checking bench for tile_router_pe_arbiter: directed steps plus
// randomized traffic against a transaction-level round-robin model.
module tb_tile_router_pe_arbiter;

   localparam int unsigned DW = 64;
   localparam int BL = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] pe_data [4];
   logic [3:0]    pe_valid;
   logic [3:0]    pe_acc;
   logic [DW-1:0] r_data;
   logic [1:0]    r_src;
   logic          r_valid;
   logic          r_acc = 1'b1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [DW-1:0] pe_q [4][$];
   bit            pe_en [4];
   logic [DW-1:0] obs_data [$];
   logic [1:0]    obs_src [$];
   int            obs_cyc [$];
   logic [DW-1:0] exp_data [$];
   logic [1:0]    exp_src [$];
   int            exp_kind [$];   // 0: same burst, 1: new grant after full burst, 2: other
   bit            prev_stall = 1'b0;
   logic [DW-1:0] prev_data;
   logic [1:0]    prev_src;

   always #5 clk = ~clk;

   tile_router_pe_arbiter #(.DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(8)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .pe0_datain            (pe_data[0]),
      .pe0_datain_valid      (pe_valid[0]),
      .pe0_datain_accept     (pe_acc[0]),
      .pe1_datain            (pe_data[1]),
      .pe1_datain_valid      (pe_valid[1]),
      .pe1_datain_accept     (pe_acc[1]),
      .pe2_datain            (pe_data[2]),
      .pe2_datain_valid      (pe_valid[2]),
      .pe2_datain_accept     (pe_acc[2]),
      .pe3_datain            (pe_data[3]),
      .pe3_datain_valid      (pe_valid[3]),
      .pe3_datain_accept     (pe_acc[3]),
      .router_dataout        (r_data),
      .router_dataout_src    (r_src),
      .router_dataout_valid  (r_valid),
      .router_dataout_accept (r_acc)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         pe_valid[i] = pe_en[i] && (pe_q[i].size() > 0);
         pe_data[i]  = pe_valid[i] ? pe_q[i][0] : '0;
      end
   endtask

   // One clock: sample at negedge, advance sources after the posedge.
   task automatic cycle();
      logic [3:0] pop;
      @(negedge clk);
      pop = '0;
      if (!rst) begin
         chk("acc_onehot", 64'($countones(pe_acc) <= 1), 64'd1);
         chk("acc_needs_valid", 64'(pe_acc & ~pe_valid), 64'd0);
         if (r_valid && !r_acc) chk("stall_no_acc", 64'(pe_acc), 64'd0);
         if (prev_stall) begin
            chk("stall_valid", 64'(r_valid), 64'd1);
            chk("stall_data", r_data, prev_data);
            chk("stall_src", 64'(r_src), 64'(prev_src));
         end
         pop = pe_acc & pe_valid;
         if (r_valid && r_acc) begin
            obs_data.push_back(r_data);
            obs_src.push_back(r_src);
            obs_cyc.push_back(cyc);
         end
      end
      prev_stall = !rst && r_valid && !r_acc;
      prev_data  = r_data;
      prev_src   = r_src;
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 4; i++) if (pop[i]) void'(pe_q[i].pop_front());
      drive();
      #1;
   endtask

   task automatic clear_all();
      for (int i = 0; i < 4; i++) begin
         pe_q[i].delete();
         pe_en[i] = 1'b0;
      end
      obs_data.delete(); obs_src.delete(); obs_cyc.delete();
      exp_data.delete(); exp_src.delete(); exp_kind.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      r_acc = 1'b1;
      clear_all();
      drive();
      cycle();
      cycle();
      chk("rst_valid", 64'(r_valid), 64'd0);
      rst = 1'b0;
      obs_data.delete(); obs_src.delete(); obs_cyc.delete();
      drive();
   endtask

   // Transaction-level model: round-robin from pointer 0, each grant takes
   // up to BL beats or until the PE has nothing left.
   task automatic gen_expected();
      logic [DW-1:0] m [4][$];
      int rr, idx, n;
      bit first, last_full;
      rr = 0; first = 1'b1; last_full = 1'b0;
      exp_data.delete(); exp_src.delete(); exp_kind.delete();
      for (int i = 0; i < 4; i++) m[i] = pe_q[i];
      while (m[0].size() + m[1].size() + m[2].size() + m[3].size() > 0) begin
         idx = -1;
         for (int k = 0; k < 4; k++)
            if (idx < 0 && m[(rr + k) % 4].size() > 0) idx = (rr + k) % 4;
         n = 0;
         while (n < BL && m[idx].size() > 0) begin
            exp_data.push_back(m[idx].pop_front());
            exp_src.push_back(2'(idx));
            exp_kind.push_back(n > 0 ? 0 : (first ? 2 : (last_full ? 1 : 2)));
            n++;
         end
         last_full = (n == BL);
         first = 1'b0;
         rr = (idx + 1) % 4;
      end
   endtask

   task automatic push_exp(input logic [DW-1:0] d, input logic [1:0] s);
      exp_data.push_back(d); exp_src.push_back(s); exp_kind.push_back(2);
   endtask

   task automatic wait_obs(input int n, input string tag);
      int w;
      w = 0;
      while (obs_data.size() < n && w < 500) begin cycle(); w++; end
      chk(tag, 64'(obs_data.size() >= n), 64'd1);
   endtask

   task automatic run_compare(input string tag, input bit rand_acc, input bit chk_gap);
      int budget, lim, g;
      budget = 0;
      while (obs_data.size() < exp_data.size() && budget < 3000) begin
         r_acc = rand_acc ? ($urandom_range(0, 3) != 0) : 1'b1;
         cycle();
         budget++;
      end
      r_acc = 1'b1;
      repeat (12) cycle();
      chk({tag, "_count"}, 64'(obs_data.size()), 64'(exp_data.size()));
      lim = (obs_data.size() < exp_data.size()) ? obs_data.size() : exp_data.size();
      for (int i = 0; i < lim; i++) begin
         chk({tag, "_data"}, obs_data[i], exp_data[i]);
         chk({tag, "_src"}, 64'(obs_src[i]), 64'(exp_src[i]));
         if (chk_gap && i > 0 && exp_kind[i] != 2) begin
            g = obs_cyc[i] - obs_cyc[i-1];
            chk({tag, "_gap"}, 64'(g), (exp_kind[i] == 0) ? 64'd1 : 64'd2);
         end
      end
   endtask

   initial begin
      // Reset with all PEs requesting, then round-robin fairness.
      clear_all();
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < 16; k++) pe_q[i].push_back(64'((i + 1) * 32'h1000 + k));
         pe_en[i] = 1'b1;
      end
      drive();
      gen_expected();
      repeat (2) begin
         cycle();
         chk("reset_valid", 64'(r_valid), 64'd0);
         chk("reset_acc", 64'(pe_acc), 64'd0);
      end
      rst = 1'b0;
      drive();
      cycle();
      chk("grant_bubble_valid", 64'(r_valid), 64'd0);
      chk("grant_pe0_acc", 64'(pe_acc), 64'd1);
      cycle();
      chk("first_beat_valid", 64'(r_valid), 64'd1);
      chk("first_beat_data", r_data, 64'h1000);
      chk("first_beat_src", 64'(r_src), 64'd0);
      run_compare("rr", 1'b0, 1'b1);
      for (int g = 0; g < 5; g++)
         if (obs_src.size() > 8 * g) chk("rr_order", 64'(obs_src[8 * g]), 64'(g % 4));

      // Single source: PE1 streams 0x100..0x10F.
      do_reset();
      for (int k = 0; k < 16; k++) pe_q[1].push_back(64'(32'h100 + k));
      pe_en[1] = 1'b1;
      drive();
      gen_expected();
      run_compare("single", 1'b0, 1'b1);

      // Truncated burst: PE2 sends 3 beats; PE0 joins later, PE3 must win (rr=3).
      do_reset();
      for (int k = 0; k < 3; k++) pe_q[2].push_back(64'(32'h200 + k));
      for (int k = 0; k < 4; k++) pe_q[3].push_back(64'(32'h300 + k));
      for (int k = 0; k < 4; k++) pe_q[0].push_back(64'(32'h400 + k));
      pe_en[2] = 1'b1; pe_en[3] = 1'b1;
      drive();
      for (int k = 0; k < 3; k++) push_exp(64'(32'h200 + k), 2'd2);
      for (int k = 0; k < 4; k++) push_exp(64'(32'h300 + k), 2'd3);
      for (int k = 0; k < 4; k++) push_exp(64'(32'h400 + k), 2'd0);
      wait_obs(1, "trunc_wait");
      pe_en[0] = 1'b1;
      drive();
      run_compare("trunc", 1'b0, 1'b0);

      // Backpressure mid-burst must neither drop beats nor truncate the grant.
      do_reset();
      for (int k = 0; k < 16; k++) pe_q[0].push_back(64'(32'h500 + k));
      for (int k = 0; k < 8; k++) pe_q[1].push_back(64'(32'h600 + k));
      pe_en[0] = 1'b1; pe_en[1] = 1'b1;
      drive();
      gen_expected();
      wait_obs(3, "bp_wait");
      r_acc = 1'b0;
      repeat (5) begin
         #1;
         chk("bp_acc", 64'(pe_acc), 64'd0);
         cycle();
         chk("bp_valid", 64'(r_valid), 64'd1);
      end
      r_acc = 1'b1;
      run_compare("bp", 1'b0, 1'b0);

      // Reset after 4 beats of a PE1 burst; arbitration restarts at PE0.
      do_reset();
      for (int k = 0; k < 16; k++) pe_q[1].push_back(64'(32'h700 + k));
      pe_en[1] = 1'b1;
      drive();
      wait_obs(4, "rstmid_wait");
      for (int k = 0; k < 4; k++)
         if (obs_data.size() > k) chk("rstmid_pre_data", obs_data[k], 64'(32'h700 + k));
      rst = 1'b1;
      r_acc = 1'b0;
      cycle();
      chk("rstmid_valid", 64'(r_valid), 64'd0);
      chk("rstmid_acc", 64'(pe_acc), 64'd0);
      clear_all();
      for (int k = 0; k < 2; k++) pe_q[0].push_back(64'(32'h800 + k));
      for (int k = 0; k < 2; k++) pe_q[1].push_back(64'(32'h900 + k));
      pe_en[0] = 1'b1; pe_en[1] = 1'b1;
      drive();
      cycle();
      rst = 1'b0;
      r_acc = 1'b1;
      drive();
      for (int k = 0; k < 2; k++) push_exp(64'(32'h800 + k), 2'd0);
      for (int k = 0; k < 2; k++) push_exp(64'(32'h900 + k), 2'd1);
      run_compare("rstmid", 1'b0, 1'b0);

      // Randomized loads and downstream backpressure against the model.
      repeat (3) begin
         do_reset();
         for (int i = 0; i < 4; i++) begin
            int n;
            n = $urandom_range(0, 20);
            for (int k = 0; k < n; k++) pe_q[i].push_back({$urandom, $urandom});
            pe_en[i] = 1'b1;
         end
         drive();
         gen_expected();
         run_compare("rand", 1'b1, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
